regfile_wb: RTL and testbench

REGFILE_WB -- requirements
Module: regfile_wb

---
 rtl/regfile_wb_pkg.sv | 7 +
 rtl/regfile_wb_demux.sv | 24 ++
 rtl/regfile_wb.sv | 71 +++++++
 tb/tb_regfile_wb.sv | 138 +++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared RISC-V register-file constants used by the pipeline blocks.
package regfile_wb_pkg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned AW     = 5;
  localparam int unsigned X0_IDX = 0;
endpackage

// File: rtl/regfile_wb_demux.sv
// Write-back address decode: one-hot register enable, x0 never enabled.
module wb_demux
  import regfile_wb_pkg::*;
#(
  parameter int unsigned NREG_P = NREG,
  parameter int unsigned AW_P   = AW
) (
  input  logic              we,
  input  logic [AW_P-1:0]   waddr,
  output logic [NREG_P-1:0] en
);
  localparam logic [AW_P-1:0] X0 = AW_P'(X0_IDX);

  // Decode waddr to a single enable bit, dropping writes to x0.
  always_comb begin
    en = {NREG_P{1'b0}};
    if (we && (waddr != X0)) begin
      en[waddr] = 1'b1;
    end else begin
      en = {NREG_P{1'b0}};
    end
    en[X0_IDX] = 1'b0;
  end
endmodule

// File: rtl/regfile_wb.sv
// Architectural register file with write-back port, write-through bypass and a one-hot write trace.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int unsigned XLEN_P = XLEN,
  parameter int unsigned NREG_P = NREG,
  parameter int unsigned AW_P   = AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW_P-1:0]   waddr,
  input  logic [XLEN_P-1:0] wdata,
  input  logic [AW_P-1:0]   raddr1,
  input  logic [AW_P-1:0]   raddr2,
  output logic [XLEN_P-1:0] rdata1,
  output logic [XLEN_P-1:0] rdata2,
  output logic [NREG_P-1:0] wr_onehot
);
  localparam logic [AW_P-1:0] X0 = AW_P'(X0_IDX);

  logic [XLEN_P-1:0] regs_r [NREG_P];
  logic [NREG_P-1:0] en_s;
  logic [NREG_P-1:0] wr_onehot_r;
  logic              wr_live_s;

  wb_demux #(
    .NREG_P (NREG_P),
    .AW_P   (AW_P)
  ) u_demux (
    .we    (we),
    .waddr (waddr),
    .en    (en_s)
  );

  assign wr_live_s = we && (waddr != X0);
  assign wr_onehot = wr_onehot_r;

  // Register storage and write trace; reset wins over any write on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG_P); i++) begin
        regs_r[i] <= {XLEN_P{1'b0}};
      end
      wr_onehot_r <= {NREG_P{1'b0}};
    end else begin
      for (int i = 0; i < int'(NREG_P); i++) begin
        if (en_s[i]) begin
          regs_r[i] <= wdata;
        end
      end
      wr_onehot_r <= en_s;
    end
  end

  // Combinational reads; x0 storage is never written so it always reads zero.
  always_comb begin
    rdata1 = regs_r[raddr1];
    rdata2 = regs_r[raddr2];
    if (wr_live_s && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end else begin
      rdata1 = regs_r[raddr1];
    end
    if (wr_live_s && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end else begin
      rdata2 = regs_r[raddr2];
    end
  end
endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed vector table, reset corners, randomized model check.
module tb_regfile_wb;
  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] wr_onehot;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        w;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] eoh;
  } vec_t;

  vec_t tbl [11];
  logic [31:0] mem [32];

  regfile_wb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .rdata1    (rdata1),
    .rdata2    (rdata2),
    .wr_onehot (wr_onehot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle: check reads before the edge, the write trace after it.
  task automatic cyc(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] a1, input logic [4:0] a2,
                     input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] eoh,
                     input string tag);
    rst_n = r; we = w; waddr = wa; wdata = wd; raddr1 = a1; raddr2 = a2;
    #2;
    chk({tag, " rdata1"}, rdata1, e1);
    chk({tag, " rdata2"}, rdata2, e2);
    @(posedge clk);
    #1;
    chk({tag, " wr_onehot"}, wr_onehot, eoh);
  endtask

  function automatic logic [31:0] model_rd(input logic w, input logic [4:0] wa,
                                           input logic [31:0] wd, input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (w && (wa == a)) return wd;
    return mem[a];
  endfunction

  initial begin
    rst_n = 1'b0; we = 1'b0; waddr = 5'd0; wdata = 32'd0; raddr1 = 5'd0; raddr2 = 5'd0;

    tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0000_0020};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    tbl[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
    tbl[4]  = '{1'b1, 5'd7,  32'h0000000A, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0000_0080};
    tbl[5]  = '{1'b1, 5'd7,  32'h12345678, 5'd5,  5'd7,  32'hDEADBEEF, 32'h12345678, 32'h0000_0080};
    tbl[6]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h12345678, 32'h12345678, 32'h0};
    tbl[7]  = '{1'b1, 5'd31, 32'h00000001, 5'd30, 5'd31, 32'h0,        32'h1,        32'h8000_0000};
    tbl[8]  = '{1'b1, 5'd31, 32'h00000002, 5'd31, 5'd31, 32'h2,        32'h2,        32'h8000_0000};
    tbl[9]  = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd30, 32'h2,        32'h0,        32'h0};
    tbl[10] = '{1'b1, 5'd9,  32'h00000055, 5'd9,  5'd5,  32'h55,       32'hDEADBEEF, 32'h0000_0200};

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset wr_onehot", wr_onehot, 32'h0);

    for (int a = 0; a < 32; a++) begin
      cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a), 32'h0, 32'h0, 32'h0, $sformatf("reset read x%0d", a));
    end

    for (int i = 0; i < 11; i++) begin
      cyc(1'b1, tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].a1, tbl[i].a2,
          tbl[i].e1, tbl[i].e2, tbl[i].eoh, $sformatf("vec%0d", i));
    end

    // Reset edge carrying a write to x10: both x9 and x10 must end up cleared.
    cyc(1'b0, 1'b1, 5'd10, 32'h66, 5'd9, 5'd10, 32'h55, 32'h66, 32'h0, "reset with write");
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd10, 32'h0, 32'h0, 32'h0, "post reset x9 x10");
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, "reset again");
    cyc(1'b1, 1'b1, 5'd3, 32'h77, 5'd3, 5'd4, 32'h77, 32'h0, 32'h0000_0008, "bypass after reset");

    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, "rand init reset");

    for (int n = 0; n < 400; n++) begin
      logic        r, w;
      logic [4:0]  wa, a1, a2;
      logic [31:0] wd, e1, e2, eoh;
      r  = ($urandom_range(0, 19) != 0);
      w  = $urandom_range(0, 1) == 1;
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      e1 = model_rd(w, wa, wd, a1);
      e2 = model_rd(w, wa, wd, a2);
      eoh = (r && w && wa != 5'd0) ? (32'd1 << wa) : 32'd0;
      cyc(r, w, wa, wd, a1, a2, e1, e2, eoh, $sformatf("rand%0d", n));
      if (!r) begin
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
      end else if (w && wa != 5'd0) begin
        mem[wa] = wd;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
